// File: rtl/tele_pkg.sv
// ----------------------------------------------------------------------------
// tele_pkg
// Shared definitions for tele serial-link masters.
//   TELE_* localparams : frame geometry and sync pattern
//   tele_state_e       : transmit FSM state encoding
//   tele_build_frame() : {sync, addr, data, even parity} as a 16-bit word
// ----------------------------------------------------------------------------
package tele_pkg;

   localparam logic [3:0] TELE_SYNC    = 4'b1010;
   localparam int         TELE_FRAME_W = 16;
   localparam int         TELE_ADDR_W  = 7;
   localparam int         TELE_DATA_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } tele_state_e;

   // Bit 0 makes the XOR over all 16 bits zero (even parity).
   function automatic logic [TELE_FRAME_W-1:0] tele_build_frame(
      input logic [TELE_ADDR_W-1:0] addr,
      input logic [TELE_DATA_W-1:0] data
   );
      logic [TELE_FRAME_W-1:0] f;
      f    = {TELE_SYNC, addr, data, 1'b0};
      f[0] = ^f[TELE_FRAME_W-1:1];
      return f;
   endfunction

endpackage

// File: rtl/tele_tx_arb_if.sv
// ----------------------------------------------------------------------------
// tele_tx_arb_if
// Requester-side bus of the tele transmit arbiter.
//   i_req    : per-requester frame request (held until granted)
//   i_addr   : packed 7-bit addresses, requester k at [7k+6:7k]
//   i_data   : packed 4-bit data, requester k at [4k+3:4k]
//   o_gnt    : one-hot combinational accept
//   o_gnt_id : index of last accepted requester
//   o_tx     : serial line (idle 0)
//   o_busy   : arbiter not in IDLE
// master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface tele_tx_arb_if import tele_pkg::*; #(
   parameter int N_REQ = 4
) ();

   logic [N_REQ-1:0]             i_req;
   logic [TELE_ADDR_W*N_REQ-1:0] i_addr;
   logic [TELE_DATA_W*N_REQ-1:0] i_data;
   logic [N_REQ-1:0]             o_gnt;
   logic [2:0]                   o_gnt_id;
   logic                         o_tx;
   logic                         o_busy;

   modport master (
      output i_req, i_addr, i_data,
      input  o_gnt, o_gnt_id, o_tx, o_busy
   );

   modport slave (
      input  i_req, i_addr, i_data,
      output o_gnt, o_gnt_id, o_tx, o_busy
   );

endinterface

// File: rtl/tele_rr_arb.sv
// ----------------------------------------------------------------------------
// tele_rr_arb
// Combinational round-robin one-hot picker.
//   req_i : request vector
//   ptr_i : index of the last winner; search starts at ptr_i+1 (mod N)
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted requester
//   vld_o : some request present
// ----------------------------------------------------------------------------
module tele_rr_arb #(
   parameter int N = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [2:0]   ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [2:0]   idx_o,
   output logic         vld_o
);

   logic [3:0] pos;
   logic       found;

   assign vld_o = |req_i;

   // Walk offsets 1..N from the pointer; the first live request wins.
   // pos never exceeds 2N-1, so one conditional subtract wraps it.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 1; k <= N; k++) begin
         pos = {1'b0, ptr_i} + 4'(k);
         if (pos >= 4'(N)) pos = pos - 4'(N);
         for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (pos == 4'(j))) begin
               found    = 1'b1;
               gnt_o[j] = 1'b1;
               idx_o    = 3'(j);
            end
         end
      end
   end

endmodule

// File: rtl/tele_tx_arb.sv
// ----------------------------------------------------------------------------
// tele_tx_arb
// Round-robin arbiter + serializer for the 1-bit tele line. Accepts one
// (addr, data) request in IDLE, shifts a 16-bit frame out MSB-first, then
// holds the line at 0 for GAP cycles before granting again.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tele_tx_arb_if.slave (requests in, grant/line/status out)
// ----------------------------------------------------------------------------
module tele_tx_arb import tele_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int GAP   = 16
) (
   input  logic          clk,
   input  logic          rst,
   tele_tx_arb_if.slave  bus
);

   tele_state_e             state_q, state_d;
   logic [2:0]              ptr_q, ptr_d;
   logic [2:0]              gnt_id_q, gnt_id_d;
   logic [TELE_FRAME_W-1:0] sh_q, sh_d;
   logic [3:0]              bit_cnt_q, bit_cnt_d;
   logic [7:0]              gap_cnt_q, gap_cnt_d;
   logic                    tx_q, tx_d;
   logic                    busy_q;

   logic [N_REQ-1:0]        arb_gnt;
   logic [2:0]              arb_idx;
   logic                    arb_vld;
   logic [TELE_ADDR_W-1:0]  sel_addr;
   logic [TELE_DATA_W-1:0]  sel_data;
   logic [TELE_FRAME_W-1:0] frame;

   tele_rr_arb #(.N(N_REQ)) u_rr (
      .req_i (bus.i_req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (arb_gnt[j]) begin
            sel_addr = bus.i_addr[j*TELE_ADDR_W +: TELE_ADDR_W];
            sel_data = bus.i_data[j*TELE_DATA_W +: TELE_DATA_W];
         end
      end
   end

   assign frame        = tele_build_frame(sel_addr, sel_data);
   assign bus.o_gnt    = (state_q == ST_IDLE) ? arb_gnt : '0;
   assign bus.o_gnt_id = gnt_id_q;
   assign bus.o_tx     = tx_q;
   assign bus.o_busy   = busy_q;

   // tx_q is loaded with frame[15] on the handshake edge itself so the first
   // bit is on the line the very next cycle; sh_q holds the remaining bits
   // left-aligned. bit_cnt_q is the index (0..15) of the bit currently on tx_q.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_id_d  = gnt_id_q;
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      tx_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               ptr_d     = arb_idx;
               gnt_id_d  = arb_idx;
               tx_d      = frame[TELE_FRAME_W-1];
               sh_d      = {frame[TELE_FRAME_W-2:0], 1'b0};
               bit_cnt_d = '0;
               state_d   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bit_cnt_q == 4'd15) begin
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end else begin
               tx_d      = sh_q[TELE_FRAME_W-1];
               sh_d      = {sh_q[TELE_FRAME_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 8'(GAP-1)) state_d = ST_IDLE;
            else                       gap_cnt_d = gap_cnt_q + 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 3'(N_REQ-1);
         gnt_id_q  <= '0;
         sh_q      <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         tx_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_id_q  <= gnt_id_d;
         sh_q      <= sh_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         tx_q      <= tx_d;
         busy_q    <= (state_d != ST_IDLE);
      end
   end

endmodule
